// File: rtl/riscv_mdu_pkg.sv
// Shared MDU definitions: funct3 encodings, divider-sequencer state and cache entry layout.
package riscv_mdu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MDU_DIV  = 3'd4;
  localparam logic [2:0] MDU_DIVU = 3'd5;
  localparam logic [2:0] MDU_REM  = 3'd6;
  localparam logic [2:0] MDU_REMU = 3'd7;

  localparam logic [XLEN-1:0] DIV_OVF_A = XLEN'(32'h8000_0000);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_FAST,
    DIV_BUSY,
    DIV_DRAIN
  } div_ctrl_state_t;

  // Last divider run; uns mirrors mdu_op[0] of that run.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            uns;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
  } div_cache_t;

  // Extend an operand to the divider width; sgn selects sign extension.
  function automatic logic [XLEN:0] div_ext(input logic [XLEN-1:0] v, input logic sgn);
    return {sgn & v[XLEN-1], v};
  endfunction

endpackage

// File: rtl/riscv_div_ctrl_if.sv
// MDU issue/result port of the divider sequencer.
interface riscv_div_ctrl_if;
  import riscv_mdu_pkg::*;

  logic            req_i;
  logic            rdy_o;
  logic [2:0]      mdu_op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            kill_i;
  logic            res_valid_o;
  logic [XLEN-1:0] res_o;

  modport master (
    output req_i, mdu_op_i, a_i, b_i, kill_i,
    input  rdy_o, res_valid_o, res_o
  );

  modport slave (
    input  req_i, mdu_op_i, a_i, b_i, kill_i,
    output rdy_o, res_valid_o, res_o
  );

endinterface

// File: rtl/riscv_div_special.sv
// Single-cycle resolution of divide-by-zero, signed overflow and zero dividend.
module riscv_div_special
  import riscv_mdu_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            is_special,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  logic sgn;

  assign sgn = (op == MDU_DIV) || (op == MDU_REM);

  // Priority: b == 0, then signed overflow, then a == 0.
  always_comb begin
    is_special = 1'b0;
    quot       = '0;
    rem        = '0;
    if (b == '0) begin
      is_special = 1'b1;
      quot       = '1;
      rem        = a;
    end else if (sgn && (a == DIV_OVF_A) && (b == '1)) begin
      is_special = 1'b1;
      quot       = DIV_OVF_A;
    end else if (a == '0) begin
      is_special = 1'b1;
    end
  end

endmodule

// File: rtl/riscv_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer in front of a multi-cycle divider, with
// fast-path special cases, a one-entry result cache and kill/drain handling.
module riscv_div_ctrl
  import riscv_mdu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  riscv_div_ctrl_if.slave mdu,
  output logic            div_start_o,
  output logic [XLEN:0]   div_a_o,
  output logic [XLEN:0]   div_b_o,
  output logic            div_rem_op_o,
  input  logic            div_done_i,
  input  logic [XLEN-1:0] div_quot_i,
  input  logic [XLEN-1:0] div_rem_i
);

  div_ctrl_state_t state_q;
  logic            res_valid_q;
  div_cache_t      cache_q;
  logic            cache_v_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic            uns_q;

  logic            sp_hit;
  logic [XLEN-1:0] sp_quot;
  logic [XLEN-1:0] sp_rem;
  logic            accept_c;
  logic            cache_hit_c;
  logic            sgn_c;
  logic [XLEN-1:0] fast_res_c;

  riscv_div_special u_special (
    .op         (mdu.mdu_op_i),
    .a          (mdu.a_i),
    .b          (mdu.b_i),
    .is_special (sp_hit),
    .quot       (sp_quot),
    .rem        (sp_rem)
  );

  always_comb begin
    accept_c    = mdu.req_i && mdu.rdy_o && !mdu.kill_i && (state_q == DIV_IDLE);
    sgn_c       = !mdu.mdu_op_i[0];
    cache_hit_c = cache_v_q && (cache_q.a == mdu.a_i) && (cache_q.b == mdu.b_i)
                  && (cache_q.uns == mdu.mdu_op_i[0]);
    if (mdu.mdu_op_i[1]) fast_res_c = sp_hit ? sp_rem  : cache_q.rem;
    else                 fast_res_c = sp_hit ? sp_quot : cache_q.quot;
  end

  // A kill arriving while the fast result is on the bus still cancels it.
  assign mdu.res_valid_o = res_valid_q && !((state_q == DIV_FAST) && mdu.kill_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= DIV_IDLE;
      mdu.rdy_o    <= 1'b1;
      res_valid_q  <= 1'b0;
      mdu.res_o    <= '0;
      div_start_o  <= 1'b0;
      div_a_o      <= '0;
      div_b_o      <= '0;
      div_rem_op_o <= 1'b0;
      cache_q      <= '0;
      cache_v_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      uns_q        <= 1'b0;
    end else begin
      div_start_o <= 1'b0;
      res_valid_q <= 1'b0;
      unique case (state_q)
        DIV_IDLE: begin
          if (accept_c) begin
            a_q       <= mdu.a_i;
            b_q       <= mdu.b_i;
            uns_q     <= mdu.mdu_op_i[0];
            mdu.rdy_o <= 1'b0;
            if (sp_hit || cache_hit_c) begin
              mdu.res_o   <= fast_res_c;
              res_valid_q <= 1'b1;
              state_q     <= DIV_FAST;
            end else begin
              div_a_o      <= div_ext(mdu.a_i, sgn_c);
              div_b_o      <= div_ext(mdu.b_i, sgn_c);
              div_rem_op_o <= mdu.mdu_op_i[1];
              div_start_o  <= 1'b1;
              state_q      <= DIV_BUSY;
            end
          end
        end
        DIV_FAST: begin
          state_q   <= DIV_IDLE;
          mdu.rdy_o <= 1'b1;
        end
        DIV_BUSY: begin
          if (div_done_i) begin
            state_q   <= DIV_IDLE;
            mdu.rdy_o <= 1'b1;
            if (!mdu.kill_i) begin
              mdu.res_o   <= div_rem_op_o ? div_rem_i : div_quot_i;
              res_valid_q <= 1'b1;
              cache_q     <= '{a: a_q, b: b_q, uns: uns_q, quot: div_quot_i, rem: div_rem_i};
              cache_v_q   <= 1'b1;
            end
          end else if (mdu.kill_i) begin
            state_q <= DIV_DRAIN;
          end
        end
        DIV_DRAIN: begin
          if (div_done_i) begin
            cache_v_q <= 1'b0;
            state_q   <= DIV_IDLE;
            mdu.rdy_o <= 1'b1;
          end
        end
        default: begin
          state_q   <= DIV_IDLE;
          mdu.rdy_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Self-checking bench for riscv_div_ctrl: directed corner cases plus random ops
// against an arithmetic reference and a 33-cycle behavioural divider.
module tb_riscv_div_ctrl;
  import riscv_mdu_pkg::*;

  localparam int unsigned LAT = 33;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  riscv_div_ctrl_if mdu ();
  logic            div_start_o, div_rem_op_o, div_done_i;
  logic [XLEN:0]   div_a_o, div_b_o;
  logic [XLEN-1:0] div_quot_i, div_rem_i;

  riscv_div_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mdu          (mdu),
    .div_start_o  (div_start_o),
    .div_a_o      (div_a_o),
    .div_b_o      (div_b_o),
    .div_rem_op_o (div_rem_op_o),
    .div_done_i   (div_done_i),
    .div_quot_i   (div_quot_i),
    .div_rem_i    (div_rem_i)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural divider: fixed latency, truncating signed division of the 33-bit operands.
  int cnt;
  time done_time;
  logic signed [XLEN:0] sa, sb, qt, rm;
  initial begin
    div_done_i = 1'b0;
    div_quot_i = '0;
    div_rem_i  = '0;
    cnt        = 0;
    done_time  = 0;
    forever begin
      @(negedge clk);
      div_done_i = 1'b0;
      if (rst_i) cnt = 0;
      else if (div_start_o) begin
        cnt = LAT;
        sa  = div_a_o;
        sb  = div_b_o;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          qt         = sa / sb;
          rm         = sa % sb;
          div_quot_i = qt[XLEN-1:0];
          div_rem_i  = rm[XLEN-1:0];
          div_done_i = 1'b1;
          done_time  = $time;
        end
      end
    end
  end

  // RV32M result rules.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Model of the reusable last divider result.
  bit          c_v = 1'b0;
  logic [31:0] c_a, c_b;
  bit          c_uns;

  // Issue one op; kill_at > 0 raises kill_i during cycle T+kill_at after the accept edge T.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int kill_at);
    bit fast, done_ok;
    int starts, valids, vk, w;
    logic [31:0] gres;
    logic [32:0] ga, gb;
    logic gro;
    time rdy_time;
    fast = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (a == 0)
           || (c_v && c_a == a && c_b == b && c_uns == op[0]);
    starts = 0; valids = 0; vk = 0; gres = '0; ga = '0; gb = '0; gro = 1'b0;
    done_ok = 1'b0; rdy_time = 0;
    w = 0;
    while (mdu.rdy_o !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    mdu.req_i = 1'b1; mdu.mdu_op_i = op; mdu.a_i = a; mdu.b_i = b;
    @(posedge clk); #1;
    mdu.req_i = 1'b0;
    for (int kk = 1; kk <= 80; kk++) begin
      mdu.kill_i = (kk == kill_at);
      @(negedge clk);
      if (div_start_o) begin
        starts++; ga = div_a_o; gb = div_b_o; gro = div_rem_op_o;
      end
      if (mdu.res_valid_o) begin
        valids++; vk = kk; gres = mdu.res_o;
      end
      if (mdu.rdy_o) begin
        done_ok = 1'b1; rdy_time = $time;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_ok) begin
      @(posedge clk); #1;
    end
    mdu.kill_i = 1'b0;

    chk({tag, "/completes"}, 64'(done_ok), 64'd1);
    chk({tag, "/starts"}, 64'(starts), fast ? 64'd0 : 64'd1);
    if (kill_at == 0) begin
      chk({tag, "/pulses"}, 64'(valids), 64'd1);
      chk({tag, "/res"}, 64'(gres), 64'(ref_res(op, a, b)));
      if (fast) chk({tag, "/fast_lat"}, 64'(vk), 64'd1);
    end else begin
      chk({tag, "/killed_pulses"}, 64'(valids), 64'd0);
    end
    if (!fast) begin
      chk({tag, "/div_a"}, 64'(ga), 64'({(op[0] ? 1'b0 : a[31]), a}));
      chk({tag, "/div_b"}, 64'(gb), 64'({(op[0] ? 1'b0 : b[31]), b}));
      chk({tag, "/rem_op"}, 64'(gro), 64'(op[1]));
      chk({tag, "/rdy_after_done"}, 64'(rdy_time - done_time), 64'd10);
      if (kill_at == 0) begin
        c_v = 1'b1; c_a = a; c_b = b; c_uns = op[0];
      end else begin
        c_v = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] pick(input bit is_b);
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return is_b ? 32'hFFFF_FFFF : 32'h8000_0000;
      2: return 32'($urandom_range(1, 20));
      3: begin
        t = 32'($urandom_range(1, 20));
        return ~t + 32'd1;
      end
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_i = 1'b1;
    mdu.req_i = 1'b0; mdu.kill_i = 1'b0; mdu.mdu_op_i = MDU_DIV; mdu.a_i = '0; mdu.b_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/rdy", 64'(mdu.rdy_o), 64'd1);
    chk("reset/res_valid", 64'(mdu.res_valid_o), 64'd0);
    chk("reset/res", 64'(mdu.res_o), 64'd0);
    chk("reset/start", 64'(div_start_o), 64'd0);
    chk("reset/div_a", 64'(div_a_o), 64'd0);
    chk("reset/div_b", 64'(div_b_o), 64'd0);
    chk("reset/rem_op", 64'(div_rem_op_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    run_op("div_neg", MDU_DIV, 32'hFFFF_3380, 32'hFFFF_FFCC, 0);
    run_op("divu_b0", MDU_DIVU, 32'd100, 32'd0, 0);
    run_op("rem_b0", MDU_REM, 32'd100, 32'd0, 0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_ovf_ops", MDU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_a0", MDU_DIV, 32'd0, 32'd5, 0);
    run_op("rem_7_2", MDU_REM, 32'd7, 32'd2, 0);
    run_op("div_7_2_hit", MDU_DIV, 32'd7, 32'd2, 0);
    run_op("divu_7_2_miss", MDU_DIVU, 32'd7, 32'd2, 0);
    run_op("kill_fast", MDU_REMU, 32'd7, 32'd2, 1);
    run_op("remu_7_2_hit", MDU_REMU, 32'd7, 32'd2, 0);

    // Request together with kill in IDLE must not be accepted.
    mdu.req_i = 1'b1; mdu.kill_i = 1'b1; mdu.mdu_op_i = MDU_DIV; mdu.a_i = 32'd9; mdu.b_i = 32'd4;
    @(posedge clk); #1;
    mdu.req_i = 1'b0; mdu.kill_i = 1'b0;
    @(negedge clk);
    chk("idle_kill/start", 64'(div_start_o), 64'd0);
    chk("idle_kill/res_valid", 64'(mdu.res_valid_o), 64'd0);
    chk("idle_kill/rdy", 64'(mdu.rdy_o), 64'd1);
    @(posedge clk); #1;

    run_op("div_1000_7", MDU_DIV, 32'd1000, 32'd7, 0);
    run_op("kill_busy", MDU_DIVU, 32'd1000, 32'd7, 4);
    run_op("div_after_drain", MDU_DIV, 32'd1000, 32'd7, 0);

    // Reset in the middle of a divider run.
    mdu.req_i = 1'b1; mdu.mdu_op_i = MDU_DIV; mdu.a_i = 32'd1000; mdu.b_i = 32'd3;
    @(posedge clk); #1;
    mdu.req_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("busy_rst/rdy", 64'(mdu.rdy_o), 64'd1);
    chk("busy_rst/res_valid", 64'(mdu.res_valid_o), 64'd0);
    chk("busy_rst/res", 64'(mdu.res_o), 64'd0);
    chk("busy_rst/start", 64'(div_start_o), 64'd0);
    chk("busy_rst/div_a", 64'(div_a_o), 64'd0);
    c_v = 1'b0;
    @(posedge clk); #1;
    run_op("div_20_3", MDU_DIV, 32'd20, 32'd3, 0);

    ra = 32'd1; rb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      rop = 3'(4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        ra = pick(1'b0);
        rb = pick(1'b1);
      end
      run_op("rand", rop, ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_div_ctrl.md
# riscv_div_ctrl

Sequencer that sits between the MDU issue port and the multi-cycle `s_divider` datapath, handling RV32M DIV/DIVU/REM/REMU. It resolves divide-by-zero, signed overflow and zero-dividend cases in one cycle without starting the divider. It reuses the last divider result when a DIV/REM pair has the same operands. All other requests are sign- or zero-extended to 33 bits, and one divider run is scheduled per request. It also supports pipeline kill and drains an in-flight division safely.

## Interface

- `XLEN`, 32: operand and result width; the divider operands are `XLEN+1` bits wide.
- `clk_i`  in  1  clock; all state is updated on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset. At top level it is inverted to drive the divider's `rstn_i`.
- `req_i`  in  1  request valid; accepted when `req_i && rdy_o`.
- `rdy_o`  out  1  controller can accept a request (high only in IDLE).
- `mdu_op_i`  in  3  funct3 field: 4 = DIV, 5 = DIVU, 6 = REM, 7 = REMU. Values 0–3 are never presented.
- `a_i`, `b_i`  in  XLEN  dividend and divisor.
- `kill_i`  in  1  flush; aborts the accepted or in-flight operation.
- `res_valid_o`  out  1  one-cycle pulse marking a valid result.
- `res_o`  out  XLEN  result; held until the next pulse.
- `div_start_o`  out  1  one-cycle start pulse to the divider.
- `div_a_o`, `div_b_o`  out  XLEN+1  extended operands, stable from start until done.
- `div_rem_op_o`  out  1  `mdu_op[1]` of the operation in flight.
- `div_done_i`  in  1  divider pulse; quotient and remainder are valid in the same cycle.
- `div_quot_i`, `div_rem_i`  in  XLEN  divider results.

## Operation

- States: IDLE, FAST, BUSY, DRAIN.
- Accept in IDLE and latch the op and operands. Then classify the request, in this priority order:
  - b == 0: quotient = all ones, remainder = a.
  - Signed op with a == 0x8000_0000 and b == 0xFFFF_FFFF: quotient = 0x8000_0000, remainder = 0.
  - a == 0: quotient = 0, remainder = 0.
  - Cache hit: cache valid, a == cached a, b == cached b, and `op[0]` (signedness) == cached signedness. The result is taken from the cached quotient or remainder.
  - Any of the above cases: go to FAST.
  - Otherwise: go to BUSY. Pulse `div_start_o` on the same edge.
- Operand extension for the divider:
  - Signed: `{a[31], a}`.
  - Unsigned: `{1'b0, a}`.
  - b is extended the same way.
- Result selection: `mdu_op[1]` = 1 selects the remainder, else the quotient.
- FAST: drive `res_o` and pulse `res_valid_o`, then return to IDLE.
- BUSY, on `div_done_i`:
  - Register the selected result and pulse `res_valid_o` on the next cycle.
  - Write the cache: a, b, signedness, quotient, remainder, valid = 1.
  - Return to IDLE.
- `kill_i` in FAST: suppress the result and return to IDLE.
- `kill_i` in BUSY without `div_done_i`: go to DRAIN.
- `kill_i` in BUSY together with `div_done_i`: suppress the result, do not write the cache, go to IDLE.
- DRAIN: wait for `div_done_i`, discard the result, clear cache valid, go to IDLE. `rdy_o` stays 0 throughout.
- `kill_i` in IDLE: no effect. `req_i` in the same cycle is not accepted.
- Special-case results are never written into the cache.

## Timing

- Reset values:
  - state = IDLE
  - `rdy_o` = 1
  - `res_valid_o` = 0, `res_o` = 0
  - `div_start_o` = 0, `div_a_o` = 0, `div_b_o` = 0, `div_rem_op_o` = 0
  - cache valid = 0
- Reset during BUSY or DRAIN: return to IDLE immediately. The divider is reset by the same edge, so no stale `div_done_i` follows.
- Fast-path latency: accept at edge T, `res_valid_o` high during cycle T+1.
- Divider-path latency:
  - Accept at T; `div_start_o` is high during cycle T+1.
  - `div_done_i` is seen at edge D; `res_valid_o` is high during cycle D+1.
  - `rdy_o` returns high in cycle D+1, so the next accept is at edge D+1 at the earliest.
- Throughput: one operation in flight at a time. Back-to-back fast operations run at one every 2 cycles.
- `div_done_i` seen in IDLE or FAST is ignored.

## Structure

- `riscv_mdu_pkg` (shared):
  - op encodings `MDU_DIV`, `MDU_DIVU`, `MDU_REM`, `MDU_REMU`
  - `div_ctrl_state_t` enum
  - `DIV_OVF_A` constant
- Sub-module `riscv_div_special`: combinational classifier.
  - Inputs: op, a, b.
  - Outputs: `is_special`, quotient, remainder.
  - Instantiated once.
- The cache registers and FSM stay in `riscv_div_ctrl`.

## Test plan

- DIV -52352 / -52, divider model with 33-cycle latency:
  - `div_start_o` pulses once.
  - `div_a_o` = 0x1_FFFF_3380.
  - `res_o` = 1006 the cycle after done.
- DIVU 100 / 0:
  - `res_o` = 0xFFFF_FFFF in cycle T+1, with no `div_start_o`.
  - Then REM 100 / 0 gives `res_o` = 100.
- DIV 0x8000_0000 / 0xFFFF_FFFF gives 0x8000_0000 via the fast path. REM with the same operands gives 0.
- REM 7 / 2 followed by DIV 7 / 2:
  - The first returns 1 through the divider.
  - The second returns 3 at T+1, with no `div_start_o` (cache hit).
  - A following DIVU 7 / 2 misses the cache and starts the divider.
- `kill_i` three cycles after `div_start_o`:
  - FSM is in DRAIN and `rdy_o` = 0 until `div_done_i`.
  - No `res_valid_o` pulse.
  - Cache is invalid afterwards: a repeat DIV starts the divider.
- `rst_i` asserted mid-BUSY:
  - Next cycle: `rdy_o` = 1 and all outputs are 0.
  - A following DIV 20 / 3 returns 6.
